// File: rtl/cmd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_pkg
// Shared types for the command/response path: the packet carried between
// parser, dispatcher and serializer, plus the response-framing definitions.
//   cmd_packet_t      : {cmd, addr, data}, one byte each
//   RESP_SYNC_DEFAULT : first byte of every response frame
//   resp_ser_state_t  : resp_serializer FSM states
//   resp_chk()        : 8-bit XOR checksum of a packet, shared with any
//                       receive-side frame checker
// ---------------------------------------------------------------------------
package cmd_pkg;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [7:0] RESP_SYNC_DEFAULT = 8'h5A;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    CMD  = 3'd2,
    ADDR = 3'd3,
    DATA = 3'd4,
    CHK  = 3'd5
  } resp_ser_state_t;

  function automatic logic [7:0] resp_chk(input cmd_packet_t pkt);
    return pkt.cmd ^ pkt.addr ^ pkt.data;
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// ---------------------------------------------------------------------------
// resp_serializer
// Pops response packets from a first-word-fall-through FIFO and writes each
// one as a framed byte stream SYNC, CMD, ADDR, DATA[, CHK] into the TX byte
// FIFO, one byte per cycle whenever that FIFO is not full.
//
// state | meaning
// IDLE  | waiting for a packet; pops it as soon as the response FIFO is valid
// SYNC  | sending SYNC_BYTE
// CMD   | sending pkt.cmd
// ADDR  | sending pkt.addr
// DATA  | sending pkt.data (last byte when INCLUDE_CHK = 0)
// CHK   | sending cmd ^ addr ^ data (last byte when INCLUDE_CHK = 1)
//
// Ports
//   clk               in   system clock, rising edge
//   rst               in   synchronous reset, active low
//   resp_fifo_valid   in   response FIFO holds a packet
//   resp_fifo_rd_data in   head packet (cmd_packet_t)
//   resp_fifo_rd_en   out  pop strobe, one cycle per packet
//   tx_fifo_full      in   TX byte FIFO full
//   tx_fifo_wr_en     out  byte write strobe
//   tx_fifo_wr_data   out  byte being written
//   busy              out  FSM not in IDLE
//   frame_done        out  pulse with the write of a frame's last byte
//   frame_cnt         out  frames completed, wraps
// ---------------------------------------------------------------------------
module resp_serializer
  import cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = RESP_SYNC_DEFAULT,
  parameter bit         INCLUDE_CHK = 1'b1,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resp_fifo_valid,
  input  cmd_packet_t          resp_fifo_rd_data,
  output logic                 resp_fifo_rd_en,
  input  logic                 tx_fifo_full,
  output logic                 tx_fifo_wr_en,
  output logic [7:0]           tx_fifo_wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  resp_ser_state_t      state_q;
  cmd_packet_t          pkt_q;
  logic [7:0]           chk_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q;
  logic [CNT_WIDTH-1:0] frame_cnt_d;
  logic                 last_byte;

  // Strobes are masked while reset is asserted so a packet is never popped,
  // nor a byte written, on a cycle whose state update is being discarded.
  assign resp_fifo_rd_en = rst && (state_q == IDLE) && resp_fifo_valid;
  assign tx_fifo_wr_en   = rst && (state_q != IDLE) && !tx_fifo_full;

  assign last_byte   = INCLUDE_CHK ? (state_q == CHK) : (state_q == DATA);
  assign frame_done  = tx_fifo_wr_en && last_byte;
  assign frame_cnt_d = frame_cnt_q + 1'b1;

  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    tx_fifo_wr_data = 8'h00;
    case (state_q)
      SYNC:    tx_fifo_wr_data = SYNC_BYTE;
      CMD:     tx_fifo_wr_data = pkt_q.cmd;
      ADDR:    tx_fifo_wr_data = pkt_q.addr;
      DATA:    tx_fifo_wr_data = pkt_q.data;
      CHK:     tx_fifo_wr_data = chk_q;
      default: tx_fifo_wr_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      chk_q       <= 8'h00;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (resp_fifo_rd_en) begin
            pkt_q   <= resp_fifo_rd_data;
            chk_q   <= resp_chk(resp_fifo_rd_data);
            state_q <= SYNC;
          end
        end
        SYNC: if (tx_fifo_wr_en) state_q <= CMD;
        CMD:  if (tx_fifo_wr_en) state_q <= ADDR;
        ADDR: if (tx_fifo_wr_en) state_q <= DATA;
        DATA: if (tx_fifo_wr_en) state_q <= INCLUDE_CHK ? CHK : IDLE;
        CHK:  if (tx_fifo_wr_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (frame_done) frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_resp_serializer.sv
module tb_resp_serializer;
  import cmd_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef int         iq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // instance with checksum byte, 16-bit counter
  logic        v1, rd1, full1, wr1, busy1, done1;
  cmd_packet_t d1;
  logic [7:0]  wd1;
  logic [15:0] cnt1;

  // instance without checksum byte, 3-bit counter (makes wrap reachable)
  logic        v0, rd0, full0, wr0, busy0, done0;
  cmd_packet_t d0;
  logic [7:0]  wd0;
  logic [2:0]  cnt0;

  resp_serializer u_dut1 (
    .clk(clk), .rst(rst),
    .resp_fifo_valid(v1), .resp_fifo_rd_data(d1), .resp_fifo_rd_en(rd1),
    .tx_fifo_full(full1), .tx_fifo_wr_en(wr1), .tx_fifo_wr_data(wd1),
    .busy(busy1), .frame_done(done1), .frame_cnt(cnt1)
  );

  resp_serializer #(.INCLUDE_CHK(1'b0), .CNT_WIDTH(3)) u_dut0 (
    .clk(clk), .rst(rst),
    .resp_fifo_valid(v0), .resp_fifo_rd_data(d0), .resp_fifo_rd_en(rd0),
    .tx_fifo_full(full0), .tx_fifo_wr_en(wr0), .tx_fifo_wr_data(wd0),
    .busy(busy0), .frame_done(done0), .frame_cnt(cnt0)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  int fmode;   // 0: never full, 1: scheduled full on dut1, 2: random full on both
  int vgate;   // 1: randomly hide valid to exercise gaps between packets
  int viol1, viol0;

  cmd_packet_t src1[$], src0[$];
  bit          fsched1[$];
  logic [7:0]  byt1[$], byt0[$], exp1[$], exp0[$];
  int          wcyc1[$], wcyc0[$], pcyc1[$], pcyc0[$], dcyc1[$], dcyc0[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int at(input iq_t q, input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic cmp_stream(input string tag, input bq_t got, input bq_t want);
    chk({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), got[i], want[i]);
  endtask

  function automatic cmd_packet_t mk(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    cmd_packet_t p;
    p.cmd = c; p.addr = a; p.data = d;
    return p;
  endfunction

  // Reference framing: what a packet must look like on the wire.
  task automatic add_exp(input cmd_packet_t p, input bit with_chk, inout bq_t q);
    q.push_back(8'h5A); q.push_back(p.cmd); q.push_back(p.addr); q.push_back(p.data);
    if (with_chk) q.push_back(p.cmd ^ p.addr ^ p.data);
  endtask

  // One clock: drive at posedge+1, observe at negedge, FIFO pop takes effect at posedge.
  task automatic cycle();
    v1 = (src1.size() > 0) && (vgate == 0 || $urandom_range(0, 3) != 0);
    d1 = (src1.size() > 0) ? src1[0] : cmd_packet_t'($urandom);
    v0 = (src0.size() > 0) && (vgate == 0 || $urandom_range(0, 3) != 0);
    d0 = (src0.size() > 0) ? src0[0] : cmd_packet_t'($urandom);
    if (fmode == 1)      full1 = (fsched1.size() > 0) ? fsched1.pop_front() : 1'b0;
    else if (fmode == 2) full1 = ($urandom_range(0, 2) == 0);
    else                 full1 = 1'b0;
    full0 = (fmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    @(negedge clk);
    if (wr1) begin byt1.push_back(wd1); wcyc1.push_back(cyc); end
    if (wr0) begin byt0.push_back(wd0); wcyc0.push_back(cyc); end
    if (wr1 && full1) viol1++;
    if (wr0 && full0) viol0++;
    if (rd1 && (busy1 || !v1)) viol1++;
    if (rd0 && (busy0 || !v0)) viol0++;
    if (done1 && !wr1) viol1++;
    if (done0 && !wr0) viol0++;
    if (done1) dcyc1.push_back(cyc);
    if (done0) dcyc0.push_back(cyc);
    if (rd1) begin pcyc1.push_back(cyc); void'(src1.pop_front()); end
    if (rd0) begin pcyc0.push_back(cyc); void'(src0.pop_front()); end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    byt1.delete(); byt0.delete(); exp1.delete(); exp0.delete();
    wcyc1.delete(); wcyc0.delete(); pcyc1.delete(); pcyc0.delete();
    dcyc1.delete(); dcyc0.delete(); fsched1.delete();
    viol1 = 0; viol0 = 0; cyc = 0;
  endtask

  task automatic do_reset();
    src1.delete(); src0.delete();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b0; v1 = 0; v0 = 0; d1 = '0; d0 = '0; full1 = 0; full0 = 0;
    fmode = 0; vgate = 0;
    @(posedge clk); #1;
    do_reset();

    // reset state
    chk("rst_busy", busy1, 0);
    chk("rst_wr_en", wr1, 0);
    chk("rst_wr_data", wd1, 8'h00);
    chk("rst_done", done1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_cnt0", cnt0, 0);

    // single packet, both framings side by side
    src1.push_back(mk(8'h52, 8'h10, 8'h3C));
    src0.push_back(mk(8'h52, 8'h10, 8'h3C));
    exp1 = '{8'h5A, 8'h52, 8'h10, 8'h3C, 8'h7E};
    exp0 = '{8'h5A, 8'h52, 8'h10, 8'h3C};
    run(12);
    chk("t1_pops", pcyc1.size(), 1);
    chk("t1_pop_cyc", at(pcyc1, 0), 0);
    cmp_stream("t1_bytes", byt1, exp1);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_wcyc%0d", i), at(wcyc1, i), i + 1);
    chk("t1_done_n", dcyc1.size(), 1);
    chk("t1_done_cyc", at(dcyc1, 0), 5);
    chk("t1_cnt", cnt1, 1);
    chk("t1_idle", busy1, 0);
    cmp_stream("t4_bytes", byt0, exp0);
    chk("t4_done_n", dcyc0.size(), 1);
    chk("t4_done_cyc", at(dcyc0, 0), 4);
    chk("t4_cnt", cnt0, 1);

    // backpressure for 3 cycles starting at the ADDR byte
    do_reset();
    fmode = 1;
    fsched1 = '{0, 0, 0, 1, 1, 1};
    src1.push_back(mk(8'h52, 8'h10, 8'h3C));
    exp1 = '{8'h5A, 8'h52, 8'h10, 8'h3C, 8'h7E};
    run(14);
    fmode = 0;
    cmp_stream("t2_bytes", byt1, exp1);
    chk("t2_wcyc_addr", at(wcyc1, 2), 6);
    chk("t2_wcyc_chk", at(wcyc1, 4), 8);
    chk("t2_len", at(wcyc1, 4) - at(pcyc1, 0), 8);
    chk("t2_viol", viol1, 0);
    chk("t2_cnt", cnt1, 1);

    // back-to-back packets
    do_reset();
    src1.push_back(mk(8'h01, 8'h02, 8'h03));
    src1.push_back(mk(8'hA0, 8'h0F, 8'hFF));
    exp1 = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h00, 8'h5A, 8'hA0, 8'h0F, 8'hFF, 8'h50};
    run(16);
    chk("t3_pops", pcyc1.size(), 2);
    chk("t3_pop_gap", at(pcyc1, 1) - at(pcyc1, 0), 6);
    cmp_stream("t3_bytes", byt1, exp1);
    chk("t3_cnt", cnt1, 2);

    // reset while in ADDR abandons the frame; next packet gets a full frame
    do_reset();
    src1.push_back(mk(8'h52, 8'h10, 8'h3C));
    src1.push_back(mk(8'h11, 8'h22, 8'h33));
    run(3);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("t5_busy", busy1, 0);
    chk("t5_wr_en", wr1, 0);
    chk("t5_wr_data", wd1, 8'h00);
    chk("t5_done", done1, 0);
    chk("t5_cnt", cnt1, 0);
    run(10);
    exp1 = '{8'h5A, 8'h52, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h00};
    cmp_stream("t5_bytes", byt1, exp1);
    chk("t5_pop2_cyc", at(pcyc1, 1), 4);
    chk("t5_cnt_after", cnt1, 1);

    // counter wrap on the narrow instance: 6 frames, then 2 more wrap to 0
    do_reset();
    for (int i = 0; i < 6; i++) src0.push_back(cmd_packet_t'($urandom));
    run(40);
    chk("t6_cnt_pre", cnt0, 6);
    dcyc0.delete();
    src0.push_back(cmd_packet_t'($urandom));
    src0.push_back(cmd_packet_t'($urandom));
    run(15);
    chk("t6_cnt_wrap", cnt0, 0);
    chk("t6_done_n", dcyc0.size(), 2);

    // random packets, random backpressure and valid gaps, both instances
    do_reset();
    fmode = 2;
    vgate = 1;
    for (int i = 0; i < 30; i++) begin
      cmd_packet_t p1, p0;
      p1 = cmd_packet_t'($urandom);
      p0 = cmd_packet_t'($urandom);
      src1.push_back(p1); add_exp(p1, 1'b1, exp1);
      src0.push_back(p0); add_exp(p0, 1'b0, exp0);
    end
    for (int k = 0; k < 3000 && !(src1.size() == 0 && src0.size() == 0 && !busy1 && !busy0); k++)
      cycle();
    chk("rnd_drained", (src1.size() == 0 && src0.size() == 0 && !busy1 && !busy0), 1);
    fmode = 0;
    vgate = 0;
    cmp_stream("rnd1", byt1, exp1);
    cmp_stream("rnd0", byt0, exp0);
    chk("rnd1_done_n", dcyc1.size(), 30);
    chk("rnd0_done_n", dcyc0.size(), 30);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("rnd1_done_at%0d", i), at(dcyc1, i), at(wcyc1, 5 * i + 4));
      chk($sformatf("rnd0_done_at%0d", i), at(dcyc0, i), at(wcyc0, 4 * i + 3));
    end
    chk("rnd1_cnt", cnt1, 30);
    chk("rnd0_cnt", cnt0, 30 % 8);
    chk("rnd1_viol", viol1, 0);
    chk("rnd0_viol", viol0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resp_serializer.md
Name: resp_serializer

Overview:
Converts response packets (cmd_packet_t) from the dispatcher's response FIFO into a framed byte stream written into the TX byte FIFO that feeds uart_tx. It is the transmit-side counterpart of cmd_parser: it sits between the response FIFO and the TX byte FIFO. Each packet becomes one frame: SYNC, CMD, ADDR, DATA, and optionally CHK. Backpressure from the TX byte FIFO is honoured byte by byte.

Parameters:
SYNC_BYTE, 8'h5A, first byte of every response frame.
INCLUDE_CHK, 1, when 1 the frame ends with a CHK byte (5 bytes total); when 0 it has no CHK byte (4 bytes total).
CNT_WIDTH, 16, width of frame_cnt.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset (0 = reset).
resp_fifo_valid  in  1  response FIFO non-empty; resp_fifo_rd_data is valid (first-word fall-through).
resp_fifo_rd_data  in  cmd_packet_t  head packet; fields used: cmd[7:0], addr[7:0], data[7:0].
resp_fifo_rd_en  out  1  pop strobe, one cycle per packet.
tx_fifo_full  in  1  TX byte FIFO full.
tx_fifo_wr_en  out  1  byte write strobe.
tx_fifo_wr_data  out  8  byte to write.
busy  out  1  high whenever state is not IDLE.
frame_done  out  1  one-cycle pulse, coincident with the write of the frame's last byte.
frame_cnt  out  CNT_WIDTH  number of frames completed; wraps to 0.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE.
  - resp_fifo_rd_en=0, tx_fifo_wr_en=0, tx_fifo_wr_data=8'h00, busy=0, frame_done=0, frame_cnt=0.
  - The latched packet is discarded; a partially sent frame is abandoned and is not resumed.
- States: IDLE, SYNC, CMD, ADDR, DATA, CHK.
- IDLE:
  - resp_fifo_rd_en is combinational: it equals resp_fifo_valid while in IDLE, and is 0 in every other state.
  - On a cycle with rd_en=1, cmd, addr and data are latched into pkt_q and the next state is SYNC.
  - CHK value is computed here: pkt_q.cmd ^ pkt_q.addr ^ pkt_q.data, stored as 8 bits.
- Byte states (SYNC, CMD, ADDR, DATA, CHK):
  - tx_fifo_wr_en = !tx_fifo_full (combinational).
  - tx_fifo_wr_data is a combinational mux of the current state's byte: SYNC_BYTE, pkt_q.cmd, pkt_q.addr, pkt_q.data, or CHK.
  - The state advances only on a cycle where wr_en=1; while full=1 the state and byte are held and nothing is written.
  - Sequence: SYNC → CMD → ADDR → DATA. From DATA, go to CHK if INCLUDE_CHK=1, otherwise to IDLE. From CHK, go to IDLE.
- Last-byte write (DATA when INCLUDE_CHK=0, CHK when INCLUDE_CHK=1):
  - frame_done=1 in the same cycle as the write.
  - frame_cnt increments on that edge, modulo 2^CNT_WIDTH (0xFFFF → 0x0000 at the default width).
- Latency and throughput:
  - Pop occurs in cycle N; SYNC is written in cycle N+1 if full=0.
  - With no backpressure, a frame occupies 5 byte cycles plus 1 IDLE cycle when INCLUDE_CHK=1 (6 cycles per packet), or 4+1 when INCLUDE_CHK=0.
  - Frames never overlap, and no new pop occurs before the frame completes.
- resp_fifo_valid deasserting mid-frame has no effect, because the packet is already latched.
- tx_fifo_full may toggle on any cycle. Every byte is written exactly once, in order, and no byte is dropped or duplicated.
- No wr_en is ever asserted while full=1.

Decomposition:
- Additions to cmd_pkg:
  - RESP_SYNC_DEFAULT = 8'h5A.
  - typedef enum logic [2:0] resp_ser_state_t {IDLE, SYNC, CMD, ADDR, DATA, CHK}.
  - function resp_chk(cmd_packet_t), returning the 8-bit XOR checksum, so a future RX-side frame checker can reuse it.
- No sub-module. The FSM, the byte mux and the counter stay in one module.

Test Plan:
1. Single packet, cmd=8'h52 addr=8'h10 data=8'h3C, full=0 → one rd_en pulse; bytes 5A,52,10,3C,7E on five consecutive cycles; frame_done on the 7E cycle; frame_cnt=1.
2. Same packet, tx_fifo_full=1 for 3 cycles starting at the ADDR byte → no wr_en during those 3 cycles; 10 written on the first cycle after full drops; total frame length 8 cycles; byte order unchanged.
3. Two packets queued back-to-back, (01,02,03) then (A0,0F,FF) → pops 6 cycles apart; streams 5A,01,02,03,00 and 5A,A0,0F,FF,50; frame_cnt=2.
4. INCLUDE_CHK=0, packet (52,10,3C) → bytes 5A,52,10,3C only; frame_done on the 3C cycle.
5. rst=0 for one cycle while in the ADDR state → next cycle is IDLE with all outputs at reset values; the next queued packet is sent as a complete new frame starting with 5A.
6. frame_cnt preloaded to 16'hFFFE via a prior run of 65534 frames (or force) → after 2 more frames, frame_cnt=16'h0000 and frame_done has pulsed twice.
